// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment patterns are active-low: bit 7 = dp, bits 6:0 = g..a.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int unsigned DP_BIT = 7;

    // Hex-to-segment table with dp off; index 0 is the rightmost entry.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble + decimal point to active-low segment pattern.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    // Table lookup, then pull the dp segment low when it is requested.
    always_comb begin
        seg_o = HEX_SEG[nib_i];
        if (dp_i) begin
            seg_o[DP_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_dyn_scan.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous update.
// New data is held in a pending register and copied to the displayed
// (shadow) copy only at a frame wrap, or immediately while the display is
// disabled, so a frame never mixes old and new digits.
// Build option: define SEG_LZB_EN for leading-zero blanking.
module seg_dyn_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIG  = 6,
    parameter int SCAN_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*NUM_DIG-1:0] data_in,
    input  logic [NUM_DIG-1:0]   dp_in,
    input  logic                 load,
    input  logic                 en,
    output logic [NUM_DIG-1:0]   sel,
    output logic [7:0]           seg,
    output logic                 frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

    logic [CNT_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]     dig_idx_q, dig_idx_d;
    logic [4*NUM_DIG-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIG-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIG-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIG-1:0]   pend_dp_q, pend_dp_d;
    logic                 pend_q, pend_d;
    logic [NUM_DIG-1:0]   sel_q, sel_d;
    logic [7:0]           seg_q, seg_d;
    logic                 frame_done_q, frame_done_d;

    logic       tick;
    logic       wrap;
    logic       commit;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_blank;
    logic [7:0] dec_seg;

    assign tick   = (scan_cnt_q == CNT_LAST) && en;
    assign wrap   = tick && (dig_idx_q == IDX_LAST);
    // While disabled the display is dark, so committing at once cannot tear.
    assign commit = pend_q && (wrap || !en);

    // Scan position, pending/shadow data hand-off and frame pulse.
    always_comb begin
        scan_cnt_d    = scan_cnt_q;
        dig_idx_d     = dig_idx_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_d        = pend_q;

        if (!en) begin
            scan_cnt_d = '0;
            dig_idx_d  = '0;
        end else if (tick) begin
            scan_cnt_d = '0;
            dig_idx_d  = wrap ? '0 : dig_idx_q + 1'b1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        if (commit) begin
            shadow_data_d = pend_data_q;
            shadow_dp_d   = pend_dp_q;
            pend_d        = 1'b0;
        end

        // A load coinciding with a commit lands after it and stays pending.
        if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pend_d      = 1'b1;
        end

        frame_done_d = wrap;
    end

    // Pick the shadow nibble/dp for the digit being scanned and build sel.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        sel_d   = '0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (dig_idx_q == IDX_W'(k)) begin
                cur_nib  = shadow_data_q[4*k +: 4];
                cur_dp   = shadow_dp_q[k];
                sel_d[k] = en;
            end
        end
    end

`ifdef SEG_LZB_EN
    // A digit is blank when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        cur_blank = 1'b0;
        for (int k = 1; k < NUM_DIG; k++) begin
            if (dig_idx_q == IDX_W'(k)) begin
                cur_blank = ((shadow_data_q >> (4*k)) == '0);
            end
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    seg_hex_decoder u_dec (
        .nib_i (cur_nib),
        .dp_i  (cur_dp),
        .seg_o (dec_seg)
    );

    // Segment pattern for the next cycle; blanking keeps the dp segment.
    always_comb begin
        seg_d = SEG_OFF;
        if (en) begin
            seg_d = dec_seg;
            if (cur_blank) begin
                seg_d[6:0] = 7'h7F;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            dig_idx_q     <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_q        <= 1'b0;
            sel_q         <= '0;
            seg_q         <= SEG_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            dig_idx_q     <= dig_idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_q        <= pend_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_dyn_scan.sv
// Self-checking bench for seg_dyn_scan with NUM_DIG=6, SCAN_DIV=4.
// Honours SEG_LZB_EN the same way as the design build.
module tb_seg_dyn_scan;

    localparam int ND  = 6;
    localparam int SD  = 4;
    localparam int FR  = ND * SD;
    localparam int BIG = 1 << 30;

    logic        clk;
    logic        rst;
    logic [23:0] data_in;
    logic [5:0]  dp_in;
    logic        load;
    logic        en;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        frame_done;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;

    // Displayed data is d0 up to sample t1, d1 up to t2, then d2.
    logic [23:0] d0, d1, d2;
    logic [5:0]  p0, p1, p2;
    int          t1, t2;

    seg_dyn_scan #(.NUM_DIG(ND), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .en         (en),
        .sel        (sel),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_seg(logic [23:0] d, logic [5:0] p, int dig);
        logic [3:0] n;
        logic [7:0] r;
        n = d[4*dig +: 4];
        case (n)
            4'h0: r = 8'hC0;  4'h1: r = 8'hF9;  4'h2: r = 8'hA4;  4'h3: r = 8'hB0;
            4'h4: r = 8'h99;  4'h5: r = 8'h92;  4'h6: r = 8'h82;  4'h7: r = 8'hF8;
            4'h8: r = 8'h80;  4'h9: r = 8'h90;  4'hA: r = 8'h88;  4'hB: r = 8'h83;
            4'hC: r = 8'hC6;  4'hD: r = 8'hA1;  4'hE: r = 8'h86;  default: r = 8'h8E;
        endcase
`ifdef SEG_LZB_EN
        if (dig != 0 && (d >> (4*dig)) == 24'h0) r[6:0] = 7'h7F;
`endif
        if (p[dig]) r[7] = 1'b0;
        return r;
    endfunction

    // Expected outputs for sample kk counted from the start of a continuous enabled scan.
    function automatic exp_t exp_at(int kk);
        exp_t        e;
        int          dg;
        logic [23:0] d;
        logic [5:0]  p;
        dg = ((kk - 1) / SD) % ND;
        d  = (kk > t2) ? d2 : (kk > t1) ? d1 : d0;
        p  = (kk > t2) ? p2 : (kk > t1) ? p1 : p0;
        e.sel = 6'b000001 << dg;
        e.seg = exp_seg(d, p, dg);
        e.fd  = ((kk % FR) == 0);
        return e;
    endfunction

    function automatic int commit_sample(int kl);
        // Load driven after sample kl is captured on edge kl+1 and
        // commits on the next frame-wrap edge.
        return ((kl / FR) + 1) * FR;
    endfunction

    task automatic settle_stage(logic [23:0] d, logic [5:0] p);
        d0 = d; p0 = p; d1 = d; p1 = p; d2 = d; p2 = p;
        t1 = BIG; t2 = BIG;
    endtask

    task automatic test_reset();
        exp_t e;
        int   pulses;
        rst = 1'b1; en = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
        settle_stage(24'h0, 6'h0);
        repeat (2) @(negedge clk);
        total++; if (sel !== 6'h00) begin bad++; $display("FAIL reset_sel got=%b want=%b", sel, 6'h00); end
        total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=%h", seg, 8'hFF); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
        rst = 1'b0;
        k = 0;
        pulses = 0;
        for (int i = 0; i < 2*FR; i++) begin
            sb_q.push_back(exp_at(k + 1));
            @(negedge clk); k++;
            e = sb_q.pop_front();
            pulses += int'(frame_done);
            total++; if (sel !== e.sel) begin bad++; $display("FAIL reset_scan_sel k=%0d got=%b want=%b", k, sel, e.sel); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL reset_scan_seg k=%0d got=%h want=%h", k, seg, e.seg); end
            total++; if (frame_done !== e.fd) begin bad++; $display("FAIL reset_scan_fd k=%0d got=%b want=%b", k, frame_done, e.fd); end
        end
        total++; if (pulses !== 2) begin bad++; $display("FAIL frame_pulses got=%0d want=2", pulses); end
    endtask

    task automatic test_commit();
        exp_t e;
        int   kl;
        kl = k + 9;
        d1 = 24'h123456; p1 = 6'h00; t1 = commit_sample(kl);
        data_in = 24'h123456; dp_in = 6'h00;
        for (int i = 0; i < 2*FR; i++) begin
            load = (k == kl);
            sb_q.push_back(exp_at(k + 1));
            @(negedge clk); k++;
            e = sb_q.pop_front();
            total++; if (sel !== e.sel) begin bad++; $display("FAIL commit_sel k=%0d got=%b want=%b", k, sel, e.sel); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL commit_seg k=%0d got=%h want=%h", k, seg, e.seg); end
            total++; if (frame_done !== e.fd) begin bad++; $display("FAIL commit_fd k=%0d got=%b want=%b", k, frame_done, e.fd); end
        end
        load = 1'b0;
        settle_stage(24'h123456, 6'h00);
    endtask

    task automatic test_double_load();
        exp_t e;
        int   ka, kb;
        ka = k + 4;
        kb = k + 14;
        d1 = 24'hABCDEF; p1 = 6'h00; t1 = commit_sample(kb);
        for (int i = 0; i < 2*FR; i++) begin
            load = (k == ka) || (k == kb);
            data_in = (k == ka) ? 24'h111111 : 24'hABCDEF;
            dp_in = 6'h00;
            sb_q.push_back(exp_at(k + 1));
            @(negedge clk); k++;
            e = sb_q.pop_front();
            total++; if (sel !== e.sel) begin bad++; $display("FAIL dbl_load_sel k=%0d got=%b want=%b", k, sel, e.sel); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL dbl_load_seg k=%0d got=%h want=%h", k, seg, e.seg); end
            total++; if (frame_done !== e.fd) begin bad++; $display("FAIL dbl_load_fd k=%0d got=%b want=%b", k, frame_done, e.fd); end
        end
        load = 1'b0;
        settle_stage(24'hABCDEF, 6'h00);
    endtask

    task automatic test_dp();
        exp_t e;
        int   kl;
        kl = k + 6;
        d1 = 24'h000000; p1 = 6'b000100; t1 = commit_sample(kl);
        data_in = 24'h000000; dp_in = 6'b000100;
        for (int i = 0; i < 2*FR; i++) begin
            load = (k == kl);
            sb_q.push_back(exp_at(k + 1));
            @(negedge clk); k++;
            e = sb_q.pop_front();
            total++; if (sel !== e.sel) begin bad++; $display("FAIL dp_sel k=%0d got=%b want=%b", k, sel, e.sel); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL dp_seg k=%0d got=%h want=%h", k, seg, e.seg); end
            total++; if (frame_done !== e.fd) begin bad++; $display("FAIL dp_fd k=%0d got=%b want=%b", k, frame_done, e.fd); end
        end
        load = 1'b0;
        settle_stage(24'h000000, 6'b000100);
    endtask

    task automatic test_load_on_commit();
        exp_t e;
        int   ka, kb;
        ka = k + 5;
        t1 = commit_sample(ka);
        kb = t1 - 1;
        t2 = t1 + FR;
        d1 = 24'h000055; p1 = 6'h00;
        d2 = 24'h0000AA; p2 = 6'b000011;
        for (int i = 0; i < 3*FR; i++) begin
            load = (k == ka) || (k == kb);
            data_in = (k == ka) ? 24'h000055 : 24'h0000AA;
            dp_in = (k == ka) ? 6'h00 : 6'b000011;
            sb_q.push_back(exp_at(k + 1));
            @(negedge clk); k++;
            e = sb_q.pop_front();
            total++; if (sel !== e.sel) begin bad++; $display("FAIL coll_sel k=%0d got=%b want=%b", k, sel, e.sel); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL coll_seg k=%0d got=%h want=%h", k, seg, e.seg); end
            total++; if (frame_done !== e.fd) begin bad++; $display("FAIL coll_fd k=%0d got=%b want=%b", k, frame_done, e.fd); end
        end
        load = 1'b0;
        settle_stage(24'h0000AA, 6'b000011);
    endtask

    task automatic test_disable();
        exp_t e;
        en = 1'b0;
        data_in = 24'h000009; dp_in = 6'h00;
        for (int i = 0; i < 6; i++) begin
            load = (i == 1);
            e.sel = 6'h00; e.seg = 8'hFF; e.fd = 1'b0;
            sb_q.push_back(e);
            @(negedge clk);
            e = sb_q.pop_front();
            total++; if (sel !== e.sel) begin bad++; $display("FAIL dis_sel i=%0d got=%b want=%b", i, sel, e.sel); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL dis_seg i=%0d got=%h want=%h", i, seg, e.seg); end
            total++; if (frame_done !== e.fd) begin bad++; $display("FAIL dis_fd i=%0d got=%b want=%b", i, frame_done, e.fd); end
        end
        load = 1'b0;
        en = 1'b1;
        k = 0;
        settle_stage(24'h000009, 6'h00);
        for (int i = 0; i < FR + 6; i++) begin
            sb_q.push_back(exp_at(k + 1));
            @(negedge clk); k++;
            e = sb_q.pop_front();
            total++; if (sel !== e.sel) begin bad++; $display("FAIL reen_sel k=%0d got=%b want=%b", k, sel, e.sel); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL reen_seg k=%0d got=%h want=%h", k, seg, e.seg); end
            total++; if (frame_done !== e.fd) begin bad++; $display("FAIL reen_fd k=%0d got=%b want=%b", k, frame_done, e.fd); end
        end
    endtask

    task automatic test_blanking();
        exp_t e;
        int   ka, kb;
        ka = k + 3;
        t1 = commit_sample(ka);
        kb = t1 + 2;
        t2 = commit_sample(kb);
        d1 = 24'h000120; p1 = 6'h00;
        d2 = 24'h000000; p2 = 6'h00;
        dp_in = 6'h00;
        for (int i = 0; i < t2 + FR - k; i++) begin
            load = (k == ka) || (k == kb);
            data_in = (k == ka) ? 24'h000120 : 24'h000000;
            sb_q.push_back(exp_at(k + 1));
            @(negedge clk); k++;
            e = sb_q.pop_front();
            total++; if (sel !== e.sel) begin bad++; $display("FAIL lzb_sel k=%0d got=%b want=%b", k, sel, e.sel); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL lzb_seg k=%0d got=%h want=%h", k, seg, e.seg); end
            total++; if (frame_done !== e.fd) begin bad++; $display("FAIL lzb_fd k=%0d got=%b want=%b", k, frame_done, e.fd); end
        end
        load = 1'b0;
        settle_stage(24'h000000, 6'h00);
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        int   kl;
        kl = k + 4;
        data_in = 24'h777777; dp_in = 6'h3F;
        for (int i = 0; i < 9; i++) begin
            load = (k == kl);
            sb_q.push_back(exp_at(k + 1));
            @(negedge clk); k++;
            e = sb_q.pop_front();
            total++; if (seg !== e.seg) begin bad++; $display("FAIL pre_rst_seg k=%0d got=%h want=%h", k, seg, e.seg); end
        end
        load = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (sel !== 6'h00) begin bad++; $display("FAIL async_rst_sel got=%b want=%b", sel, 6'h00); end
        total++; if (seg !== 8'hFF) begin bad++; $display("FAIL async_rst_seg got=%h want=%h", seg, 8'hFF); end
        @(negedge clk);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL async_rst_fd got=%b want=0", frame_done); end
        rst = 1'b0;
        k = 0;
        settle_stage(24'h000000, 6'h00);
        for (int i = 0; i < 2*FR; i++) begin
            sb_q.push_back(exp_at(k + 1));
            @(negedge clk); k++;
            e = sb_q.pop_front();
            total++; if (sel !== e.sel) begin bad++; $display("FAIL post_rst_sel k=%0d got=%b want=%b", k, sel, e.sel); end
            total++; if (seg !== e.seg) begin bad++; $display("FAIL post_rst_seg k=%0d got=%h want=%h", k, seg, e.seg); end
            total++; if (frame_done !== e.fd) begin bad++; $display("FAIL post_rst_fd k=%0d got=%b want=%b", k, frame_done, e.fd); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
        test_reset();
        test_commit();
        test_double_load();
        test_dp();
        test_load_on_commit();
        test_disable();
        test_blanking();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
